pipe_adder: RTL and testbench
=============================

PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits; legal range 2..64.
REQ-002 Parameter STAGES, default 4: number of pipeline segments; WIDTH SHALL be an integer multiple of STAGES; CHUNK = WIDTH/STAGES.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the operand beat this cycle.
REQ-007 a  input  WIDTH  addend A.
REQ-008 b  input  WIDTH  addend B.
REQ-009 cin  input  1  carry in.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts the result beat.
REQ-012 s  output  WIDTH  sum, registered.
REQ-013 cout  output  1  carry out of bit WIDTH-1, registered.
REQ-014 ovf  output  1  signed overflow; present only when PIPE_ADDER_OVF_EN is defined.

Function
REQ-015 The block SHALL compute {cout,s} = a + b + cin (unsigned, WIDTH+1 bits) for every accepted beat.
REQ-016 Stage k (k = 0..STAGES-1) SHALL add operand bits [k*CHUNK +: CHUNK] with the carry registered by stage k-1 (stage 0 uses the captured cin).
REQ-017 Each stage register SHALL hold: a valid bit, the sum chunks completed so far, the unconsumed upper operand chunks, and the carry into the next chunk.
REQ-018 A beat is accepted when in_valid && in_ready; a beat leaves when out_valid && out_ready.
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid, absent backpressure.
REQ-020 Stage k SHALL advance when its successor is empty or itself advances (bubble collapsing); the last stage advances when out_ready is high or it is empty.
REQ-021 in_ready SHALL equal the advance condition of stage 0 and SHALL depend combinationally only on stage state and out_ready, never on in_valid.
REQ-022 Sustained throughput SHALL be one beat per cycle when in_valid and out_ready are held high.
REQ-023 While out_valid is high and out_ready low, s, cout (and ovf) SHALL hold stable.
REQ-024 Beats SHALL exit in acceptance order; none SHALL be dropped or duplicated.
REQ-025 Full: with all STAGES stages occupied and out_ready low, in_ready SHALL be 0.
REQ-026 Simultaneous output pop and input push on a full pipeline SHALL both complete in the same cycle.
REQ-027 Carry across a chunk boundary SHALL be carried in the stage register, never rippled combinationally across more than CHUNK bits.

Reset
REQ-028 While rst_n is low at a rising clk edge, all stage valid bits SHALL clear and s, cout, ovf SHALL be 0; out_valid SHALL be 0 in the following cycle.
REQ-029 Reset mid-operation SHALL discard all in-flight beats; no result from before reset SHALL emerge after it.
REQ-030 in_ready SHALL be 1 in the first cycle after rst_n returns high.

Configuration
REQ-031 Macro PIPE_ADDER_OVF_EN: when defined, ovf SHALL be present and registered alongside s, equal to (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]) for that beat; the operand sign bits SHALL travel with the beat.
REQ-032 When PIPE_ADDER_OVF_EN is undefined, port ovf and its storage SHALL not exist; all other behaviour is identical.

Verification
REQ-033 WIDTH=16, STAGES=4: a=0xFFFF, b=0x0001, cin=0, out_ready=1 -> 4 cycles later out_valid=1, s=0x0000, cout=1.
REQ-034 Back-to-back: 100 random beats, in_valid and out_ready held 1 -> 100 results in order, one per cycle, all equal to the reference sum.
REQ-035 Backpressure: out_ready=0 for 10 cycles while in_valid=1 -> in_ready falls to 0 after 4 accepted beats; s held stable; releasing out_ready drains 4 beats in order.
REQ-036 Reset mid-flight: 3 beats accepted, rst_n=0 for one cycle -> out_valid=0, s=0, cout=0 next cycle; no stale beat appears afterwards.
REQ-037 With PIPE_ADDER_OVF_EN: a=0x7FFF, b=0x0001, cin=0 -> s=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> s=0x0000, cout=1, ovf=1.
REQ-038 WIDTH=8, STAGES=1 and WIDTH=8, STAGES=8: a=0x80, b=0x7F, cin=1 -> s=0x00, cout=1 after 1 and 8 cycles respectively.

Source files
------------

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result handshake bundle for pipe_adder.
// master = environment side (drives operands, consumes results);
// slave  = adder side. Port ovf exists only when PIPE_ADDER_OVF_EN is defined.
interface pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout
`ifdef PIPE_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout
`ifdef PIPE_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder split into STAGES segments of CHUNK bits.
// Each segment adds one operand chunk plus the carry registered by the
// previous segment, so no combinational carry path spans more than CHUNK
// bits. Valid/ready flow control with bubble collapsing; the last segment
// is the registered output (s, cout).
// Optional feature: define PIPE_ADDER_OVF_EN to add the registered signed
// overflow flag ovf.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  typedef logic [WIDTH-1:0] word_t;

  if ((WIDTH % STAGES) != 0 || WIDTH < 2 || WIDTH > 64) begin : g_cfg_check
    $error("pipe_adder: WIDTH must be in 2..64 and a multiple of STAGES");
  end

  // Adds one CHUNK-wide slice with carry-in; the MSB of the result is the
  // carry handed to the next segment.
  function automatic logic [CHUNK:0] add_chunk(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
  endfunction

  // Signed overflow: like-signed operands producing an unlike-signed sum.
  function automatic logic signed_ovf(
    input logic sa,
    input logic sb,
    input logic ss
  );
    return (sa == sb) && (ss != sa);
  endfunction

  // Segment registers 0..STAGES-2; segment STAGES-1 lives in the output regs.
  logic [STAGES-1:0] vld_p;
  word_t             sum_p [STAGES];
  word_t             opa_p [STAGES];
  word_t             opb_p [STAGES];
  logic              cy_p  [STAGES];

  // Output segment registers.
  word_t             s_out;
  logic              cout_out;
`ifdef PIPE_ADDER_OVF_EN
  logic              ovf_out;
  logic              nxt_ovf;
`endif

  // Per-segment advance flags and next-state values.
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] src_cy;
  logic [STAGES-1:0] nxt_cy;
  word_t             src_a   [STAGES];
  word_t             src_b   [STAGES];
  word_t             src_sum [STAGES];
  word_t             nxt_sum [STAGES];

  // Advance chain: a segment moves when it is empty or its successor moves;
  // the last segment moves when empty or the consumer takes the result.
  always_comb begin
    logic go;
    adv = '0;
    go  = !vld_p[STAGES-1] || bus.out_ready;
    adv[STAGES-1] = go;
    for (int k = STAGES - 2; k >= 0; k--) begin
      go     = !vld_p[k] || go;
      adv[k] = go;
    end
  end

  // Segment inputs and per-chunk addition; segment k only touches chunk k.
  always_comb begin
    src_vld = '0;
    src_cy  = '0;
    nxt_cy  = '0;
    src_a   = '{default: '0};
    src_b   = '{default: '0};
    src_sum = '{default: '0};
    nxt_sum = '{default: '0};

    src_vld[0] = bus.in_valid;
    src_a[0]   = bus.a;
    src_b[0]   = bus.b;
    src_sum[0] = '0;
    src_cy[0]  = bus.cin;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_p[k-1];
      src_a[k]   = opa_p[k-1];
      src_b[k]   = opb_p[k-1];
      src_sum[k] = sum_p[k-1];
      src_cy[k]  = cy_p[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      logic [CHUNK:0] res;
      res = add_chunk(src_a[k][k*CHUNK +: CHUNK], src_b[k][k*CHUNK +: CHUNK], src_cy[k]);
      nxt_sum[k] = src_sum[k];
      nxt_sum[k][k*CHUNK +: CHUNK] = res[CHUNK-1:0];
      nxt_cy[k] = res[CHUNK];
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  // Overflow is resolved when the top chunk is summed in the last segment;
  // the operand sign bits reach it inside the forwarded operand words.
  always_comb begin
    nxt_ovf = signed_ovf(src_a[STAGES-1][WIDTH-1], src_b[STAGES-1][WIDTH-1],
                         nxt_sum[STAGES-1][WIDTH-1]);
  end
`endif

  // Segment occupancy: cleared by reset, otherwise shifted on advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) vld_p[k] <= src_vld[k];
      end
    end
  end

  // Intermediate segment payload: partial sum, operands, inter-chunk carry.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES - 1; k++) begin
      if (adv[k]) begin
        sum_p[k] <= nxt_sum[k];
        opa_p[k] <= src_a[k];
        opb_p[k] <= src_b[k];
        cy_p[k]  <= nxt_cy[k];
      end
    end
  end

  // Output segment: cleared by reset, loaded only with a real beat so the
  // last result stays put across bubbles and while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_out    <= '0;
      cout_out <= 1'b0;
`ifdef PIPE_ADDER_OVF_EN
      ovf_out  <= 1'b0;
`endif
    end else if (adv[STAGES-1] && src_vld[STAGES-1]) begin
      s_out    <= nxt_sum[STAGES-1];
      cout_out <= nxt_cy[STAGES-1];
`ifdef PIPE_ADDER_OVF_EN
      ovf_out  <= nxt_ovf;
`endif
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.s         = s_out;
  assign bus.cout      = cout_out;
`ifdef PIPE_ADDER_OVF_EN
  assign bus.ovf       = ovf_out;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: directed and randomized checks of pipe_adder against a
// queue-based arithmetic reference model.
module tb_pipe_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           ovf;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;

  pipe_adder_if #(.WIDTH(WIDTH)) bus ();
  pipe_adder_if #(.WIDTH(8))     bus8a ();
  pipe_adder_if #(.WIDTH(8))     bus8b ();

  pipe_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  pipe_adder #(.WIDTH(8), .STAGES(1)) dut8_1 (.clk(clk), .rst_n(rst_n), .bus(bus8a));
  pipe_adder #(.WIDTH(8), .STAGES(8)) dut8_8 (.clk(clk), .rst_n(rst_n), .bus(bus8b));

  always #5 clk = ~clk;

  beat_t q[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_pop = 0;
  int first_pop = -1;
  int last_pop = -1;
  logic             hold_pending = 1'b0;
  logic [WIDTH-1:0] hold_s;
  logic             hold_c;

  function automatic beat_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic ci);
    beat_t r;
    r.sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
    r.ovf = (x[WIDTH-1] == y[WIDTH-1]) && (r.sum[WIDTH-1] != x[WIDTH-1]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: observe handshakes at the falling edge, update the model,
  // then advance to just after the rising edge.
  task automatic step();
    beat_t e;
    @(negedge clk);
    if (hold_pending) begin
      chk("hold_s", bus.s, hold_s);
      chk("hold_cout", bus.cout, hold_c);
    end
    hold_pending = 1'b0;
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      chk("beat_expected", (q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sum", {bus.cout, bus.s}, e.sum);
`ifdef PIPE_ADDER_OVF_EN
        chk("ovf", bus.ovf, e.ovf);
`endif
      end
      n_pop++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
    end else if (bus.out_valid === 1'b1) begin
      hold_pending = 1'b1;
      hold_s = bus.s;
      hold_c = bus.cout;
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      q.push_back(model(bus.a, bus.b, bus.cin));
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_operands();
    bus.a   = WIDTH'($urandom);
    bus.b   = WIDTH'($urandom);
    bus.cin = 1'($urandom);
  endtask

  initial begin
    int lat;
    int lat1;
    int lat8;
    int a0;
    int p0;
    int seen;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    bus8a.in_valid = 1'b0; bus8a.a = '0; bus8a.b = '0; bus8a.cin = 1'b0; bus8a.out_ready = 1'b1;
    bus8b.in_valid = 1'b0; bus8b.a = '0; bus8b.b = '0; bus8b.cin = 1'b0; bus8b.out_ready = 1'b1;

    // Reset state
    step();
    step();
    q.delete();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_s", bus.s, 0);
    chk("rst_cout", bus.cout, 0);
`ifdef PIPE_ADDER_OVF_EN
    chk("rst_ovf", bus.ovf, 0);
`endif
    rst_n = 1'b1;
    chk("rst_in_ready", bus.in_ready, 1);

    // 0xFFFF + 0x0001: latency and carry out
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'h0001; bus.cin = 1'b0;
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    chk("latency", lat, STAGES);
    chk("carry_s", bus.s, 16'h0000);
    chk("carry_cout", bus.cout, 1);
    step();

    // Narrow configurations: single segment and one bit per segment
    bus8a.in_valid = 1'b1; bus8a.a = 8'h80; bus8a.b = 8'h7F; bus8a.cin = 1'b1;
    bus8b.in_valid = 1'b1; bus8b.a = 8'h80; bus8b.b = 8'h7F; bus8b.cin = 1'b1;
    @(posedge clk); #1;
    bus8a.in_valid = 1'b0;
    bus8b.in_valid = 1'b0;
    lat1 = -1;
    lat8 = -1;
    for (int i = 1; i <= 20; i++) begin
      if (bus8a.out_valid === 1'b1 && lat1 < 0) begin
        lat1 = i;
        chk("w8s1_sum", {bus8a.cout, bus8a.s}, 9'h100);
      end
      if (bus8b.out_valid === 1'b1 && lat8 < 0) begin
        lat8 = i;
        chk("w8s8_sum", {bus8b.cout, bus8b.s}, 9'h100);
      end
      if (lat1 >= 0 && lat8 >= 0) break;
      @(posedge clk); #1;
    end
    chk("w8s1_latency", lat1, 1);
    chk("w8s8_latency", lat8, 8);

    // Back-to-back random beats at full rate
    first_pop = -1;
    a0 = n_acc;
    p0 = n_pop;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_operands();
      step();
    end
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("b2b_accepted", n_acc - a0, 100);
    chk("b2b_results", n_pop - p0, 100);
    chk("b2b_span", last_pop - first_pop, 99);
    chk("b2b_drained", q.size(), 0);

    // Backpressure: fill, stall, then push and pop together on a full pipe
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    a0 = n_acc;
    for (int i = 0; i < 10; i++) begin
      rand_operands();
      step();
    end
    chk("bp_accepted", n_acc - a0, STAGES);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    rand_operands();
    #1;
    chk("full_in_ready_on_pop", bus.in_ready, 1);
    a0 = n_acc;
    p0 = n_pop;
    step();
    chk("full_push", n_acc - a0, 1);
    chk("full_pop", n_pop - p0, 1);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("bp_drained", q.size(), 0);

    // Signed overflow corner operands
    bus.in_valid = 1'b1;
    bus.a = 16'h7FFF; bus.b = 16'h0001; bus.cin = 1'b0;
    step();
    bus.a = 16'h8000; bus.b = 16'h8000; bus.cin = 1'b0;
    step();
    bus.a = 16'h8000; bus.b = 16'h7FFF; bus.cin = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    chk("ovf_drained", q.size(), 0);

    // Reset mid-flight discards in-flight beats
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_operands();
      step();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    q.delete();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_s", bus.s, 0);
    chk("midrst_cout", bus.cout, 0);
    rst_n = 1'b1;
    chk("midrst_in_ready", bus.in_ready, 1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("no_stale_beat", seen, 0);

    // Random valid/ready mix
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = (($urandom % 10) < 7);
      bus.out_ready = (($urandom % 10) < 6);
      rand_operands();
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 30 && q.size() > 0; i++) step();
    chk("mix_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
